cmd_registry_fifo: RTL and testbench

//  Real-time command registry feeding the pulse-train sequencer (MASTER_START).

---
 rtl/cmd_registry_fifo.sv | 146 ++++++++++++++
 tb/tb_cmd_registry_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_registry_fifo.sv
// Command registry FIFO: buffers timed commands and hands them one at a time to the
// pulse-train sequencer on request. Stale-command dropping is enabled by CMD_STALE_DROP_EN.
module cmd_registry_fifo #(
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int LEAD_MARGIN = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_wr,
  input  logic [321:0]  cmd_data,
  input  logic          flush,
  input  logic          req_command,
  input  logic [63:0]   seq_time,
  output logic [321:0]  mem_cmd,
  output logic          wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic [15:0]   drop_cnt
);

  // state | meaning
  // IDLE  | waiting for a pending request and a stored entry
  // RD    | registered read of the head entry, pop it
  // CHK   | stale check against sequencer time (drop build only)
  // LOAD  | present entry on mem_cmd, pulse wr_data
  typedef enum logic [1:0] {IDLE, RD, CHK, LOAD} state_t;

  state_t        state;
  logic [321:0]  mem [0:DEPTH-1];
  logic [321:0]  entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pend;
  logic          req_d;
  logic          req_edge;
  logic          push;
  logic          pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign req_edge = req_command && !req_d;
  assign push     = cmd_wr && !full && !flush;
  assign pop      = (state == RD) && !flush;

`ifdef CMD_STALE_DROP_EN
  logic [48:0] lead_sum;
  logic [47:0] lead_lim;
  logic        stale;
  logic        unused_time_hi;

  // Saturate so a time near wrap-around cannot make every future entry look fresh.
  assign lead_sum       = {1'b0, seq_time[47:0]} + 49'(LEAD_MARGIN);
  assign lead_lim       = lead_sum[48] ? '1 : lead_sum[47:0];
  assign stale          = (entry[193:146] <= lead_lim);
  assign unused_time_hi = ^seq_time[63:48];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (state == CHK && stale && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_time;

  assign unused_time = ^seq_time;
  assign drop_cnt    = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
    if (state == RD) entry <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= 1'b1;
      req_d   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      wr_data <= 1'b0;
      mem_cmd <= '1;
    end else begin
      req_d   <= req_command;
      wr_data <= 1'b0;
      if (flush) begin
        state  <= IDLE;
        pend   <= 1'b1;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (cmd_wr && full) ovf <= 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
        if (req_edge) pend <= 1'b1;
        case (state)
          IDLE: begin
            if ((pend || req_edge) && !empty) begin
              state <= RD;
              pend  <= 1'b0;
            end
          end
          RD: begin
`ifdef CMD_STALE_DROP_EN
            state <= CHK;
`else
            state <= LOAD;
`endif
          end
`ifdef CMD_STALE_DROP_EN
          CHK: begin
            if (!stale) begin
              state <= LOAD;
            end else if (!empty) begin
              state <= RD;
            end else begin
              state <= IDLE;
              pend  <= 1'b1;
            end
          end
`endif
          LOAD: begin
            mem_cmd <= entry;
            wr_data <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_registry_fifo.sv
// Self-checking bench for cmd_registry_fifo: directed scenarios plus a randomized
// push/request phase scored against an in-order queue of accepted commands.
module tb_cmd_registry_fifo;

  localparam int DEPTH = 16;
`ifdef CMD_STALE_DROP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [321:0]  cmd_data = '0;
  logic          flush = 1'b0;
  logic          req_command = 1'b0;
  logic [63:0]   seq_time = '0;
  logic [321:0]  mem_cmd;
  logic          wr_data;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          ovf;
  logic [15:0]   drop_cnt;

  cmd_registry_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_wr(cmd_wr), .cmd_data(cmd_data), .flush(flush),
    .req_command(req_command), .seq_time(seq_time), .mem_cmd(mem_cmd),
    .wr_data(wr_data), .full(full), .empty(empty), .count(count), .ovf(ovf),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int b2b = 0;
  int max_count = 0;
  logic prev_wr = 1'b0;
  logic [321:0] got_q[$];
  int got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_data === 1'b1) begin
      got_q.push_back(mem_cmd);
      got_cyc.push_back(cyc);
      if (prev_wr) b2b <= b2b + 1;
    end
    prev_wr <= (wr_data === 1'b1);
    if (int'(count) > max_count) max_count <= int'(count);
  end

  task automatic chk(input string tag, input logic [321:0] got, input logic [321:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [321:0] mk(input logic [47:0] ts);
    logic [321:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    r[321:320] = 2'($urandom);
    r[193:146] = ts;
    return r;
  endfunction

  task automatic push(input logic [321:0] r);
    cmd_data = r;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic raise_req(output int n);
    req_command = 1'b1;
    n = cyc + 1;
    tick();
  endtask

  task automatic expect_load(input string tag, input logic [321:0] exp, output int lcyc);
    int w;
    w = 0;
    while (got_q.size() == 0 && w < 40) begin
      tick();
      w++;
    end
    if (got_q.size() == 0) begin
      chk({tag, "_timeout"}, 1'b0, 1'b1);
      lcyc = -1;
    end else begin
      chk(tag, got_q.pop_front(), exp);
      lcyc = got_cyc.pop_front();
    end
  endtask

  logic [321:0] ra, rb, rc, rd, re, rf, rg, rx, ry;
  logic [321:0] exp_q[$];
  int n, lc, p;

  initial begin
    tick(3);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_wr_data", wr_data, 1'b0);
    chk("rst_mem_cmd", mem_cmd, '1);
    rst_n = 1'b1;
    tick(2);

    // preload of the first command after reset
    ra = mk(48'd1000);
    push(ra);
    expect_load("t1_load_a", ra, lc);
    tick(2);
    chk("t1_empty", empty, 1'b1);

    // request edge latency, held level gives nothing more
    rb = mk(48'd2000);
    rc = mk(48'd3000);
    push(rb);
    push(rc);
    tick(4);
    chk("t2_no_unrequested", got_q.size(), 0);
    chk("t2_count", count, 2);
    raise_req(n);
    expect_load("t2_load_b", rb, lc);
    chk("t2_latency", lc, n + LAT);
    tick(10);
    chk("t2_held_no_load", got_q.size(), 0);
    req_command = 1'b0;
    tick();
    raise_req(n);
    expect_load("t2_load_c", rc, lc);
    req_command = 1'b0;
    tick(2);

    // fill, overflow, flush
    for (int i = 1; i <= DEPTH; i++) begin
      push(mk(48'd4000 + 48'(i)));
      if (i == DEPTH - 1) chk("t3_not_full_15", full, 1'b0);
    end
    chk("t3_full", full, 1'b1);
    chk("t3_count16", count, DEPTH);
    chk("t3_ovf_before", ovf, 1'b0);
    push(mk(48'd4100));
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_count_after17", count, DEPTH);
    cmd_data = mk(48'd4200);
    cmd_wr = 1'b1;
    flush = 1'b1;
    tick();
    cmd_wr = 1'b0;
    flush = 1'b0;
    chk("t3_flush_count", count, 0);
    chk("t3_flush_ovf", ovf, 1'b0);
    chk("t3_flush_empty", empty, 1'b1);
    tick(6);
    chk("t3_flush_beats_wr", got_q.size(), 0);

    // consume the post-flush preload, then the stale-drop scenario
    rg = mk(48'd100000);
    push(rg);
    expect_load("t4_load_g", rg, lc);
    seq_time = 64'hABCD_0000_0000_1388;
    rd = mk(48'd5020);
    re = mk(48'd9000);
    push(rd);
    push(re);
    tick(2);
    raise_req(n);
`ifdef CMD_STALE_DROP_EN
    expect_load("t4_load_e", re, lc);
    chk("t4_drop_latency", lc, n + LAT + 2);
    chk("t4_drop_cnt", drop_cnt, 1);
    req_command = 1'b0;
    tick(2);
    rx = mk(48'd5048);
    ry = mk(48'd5049);
    push(rx);
    push(ry);
    raise_req(n);
    expect_load("t4_boundary_5049", ry, lc);
    chk("t4_drop_cnt2", drop_cnt, 2);
    req_command = 1'b0;
    tick(2);
    seq_time = 64'h0000_FFFF_FFFF_FFF0;
    push(mk(48'hFFFF_FFFF_FFFF));
    raise_req(n);
    tick(15);
    chk("t4_saturated_drop", got_q.size(), 0);
    chk("t4_drop_cnt3", drop_cnt, 3);
    chk("t4_sat_empty", empty, 1'b1);
`else
    expect_load("t4_load_d", rd, lc);
    chk("t4_latency", lc, n + LAT);
    chk("t4_drop_cnt", drop_cnt, 0);
    req_command = 1'b0;
    tick();
    raise_req(n);
    expect_load("t4_load_e", re, lc);
`endif
    req_command = 1'b0;
    seq_time = '0;
    tick(2);

    // request while empty stays pending until a command arrives
    raise_req(n);
    tick(3);
    req_command = 1'b0;
    tick(10);
    chk("t5_empty_no_load", got_q.size(), 0);
    rf = mk(48'd7000);
    push(rf);
    p = cyc;
    expect_load("t5_load_f", rf, lc);
    chk("t5_latency", lc, p + LAT + 1);
    tick(2);

    // pointer wrap with one entry at a time
    max_count = 0;
    for (int i = 0; i < 40; i++) begin
      rx = mk(48'd20000 + 48'(i));
      push(rx);
      raise_req(n);
      expect_load("t6_wrap_load", rx, lc);
      req_command = 1'b0;
      tick();
    end
    chk("t6_max_count", (max_count <= 1), 1'b1);

    // reset while a fetch is in flight
    push(mk(48'd30000));
    raise_req(n);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_data", wr_data, 1'b0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_mem_cmd", mem_cmd, '1);
    tick(2);
    req_command = 1'b0;
    rst_n = 1'b1;
    tick(10);
    chk("t6_rst_no_load", got_q.size(), 0);
    chk("t6_rst_mem_hold", mem_cmd, '1);

    // randomized pushes and request toggles against an in-order reference queue
    for (int c = 0; c < 800; c++) begin
      cmd_wr = 1'b0;
      if ($urandom_range(3) == 0 && exp_q.size() < 10) begin
        rx = mk(48'd1000 + 48'($urandom_range(1 << 20)));
        cmd_data = rx;
        cmd_wr = 1'b1;
        exp_q.push_back(rx);
      end
      if ($urandom_range(2) == 0) req_command = !req_command;
      tick();
      while (got_q.size() > 0) begin
        void'(got_cyc.pop_front());
        if (exp_q.size() == 0) begin
          void'(got_q.pop_front());
          chk("rnd_unexpected_load", 1'b1, 1'b0);
        end else begin
          chk("rnd_load", got_q.pop_front(), exp_q.pop_front());
        end
      end
    end
    cmd_wr = 1'b0;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      if (c % 3 == 0) req_command = !req_command;
      tick();
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        void'(got_cyc.pop_front());
        chk("rnd_drain_load", got_q.pop_front(), exp_q.pop_front());
      end
    end
    tick(8);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_no_extra", got_q.size(), 0);
    chk("rnd_count", count, 0);
    chk("rnd_empty", empty, 1'b1);
    chk("rnd_ovf", ovf, 1'b0);
    chk("rnd_drop", drop_cnt, 0);
    chk("no_back_to_back", b2b, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
